// File: rtl/video_capture.sv
// Video-to-SDRAM frame writer: captures active pixels of each enabled frame and
// writes them as 32-bit words in raster order through a Wishbone classic master.
module video_capture #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADR   = 32'h0
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic        enable,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    output logic        frame_done,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned CW   = $clog2(NPIX + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    // Horizontal sync carries no information for a linear framebuffer.
    logic unused_hs;
    assign unused_hs = vid_hs;

    // Capture side
    logic          vs_prev_q, vs_armed_q, capturing_q, sof_pend_q, overflow_q;
    logic [CW-1:0] cnt_q;
    logic          frame_start, accept, push, pop;
    logic [25:0]   entry;

    // vs_armed_q blocks a spurious start when VS is already low at reset release.
    assign frame_start = vs_armed_q & vs_prev_q & ~vid_vs;
    assign accept      = capturing_q & vid_blank & (cnt_q < CW'(NPIX));
    assign entry       = {sof_pend_q, (cnt_q == CW'(NPIX - 1)), vid_rgb};

    // FIFO
    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty;
    logic [25:0]   head;

    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a full FIFO can still take the pixel.
    assign push  = accept & (~full | pop);

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            vs_prev_q   <= 1'b1;
            vs_armed_q  <= 1'b0;
            capturing_q <= 1'b0;
            sof_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            vs_prev_q  <= vid_vs;
            vs_armed_q <= vs_armed_q | vid_vs;
            if (frame_start) begin
                capturing_q <= enable;
                cnt_q       <= '0;
                sof_pend_q  <= 1'b1;
            end else begin
                if (accept) cnt_q <= cnt_q + CW'(1);
                if (push) sof_pend_q <= 1'b0;
            end
            if (accept && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (push) mem_q[wr_ptr_q] <= entry;
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) count_q <= count_q + (AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
        end
    end

    // Writer
    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic        cyc_q, cyc_d, eof_q, eof_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        eof_d   = eof_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wshb_ack) begin
                    done_d = eof_q;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        cyc_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            cyc_d = 1'b1;
            adr_d = head[25] ? BASE_ADR : adr_q + 32'd4;
            dat_d = {8'h00, head[23:0]};
            eof_d = head[24];
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q <= StIdle;
            adr_q   <= BASE_ADR;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign wshb_cyc    = cyc_q;
    assign wshb_stb    = cyc_q;
    assign wshb_we     = cyc_q;
    assign wshb_adr    = adr_q;
    assign wshb_dat_ms = dat_q;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign frame_done  = done_q;
    assign overflow    = overflow_q;
    assign busy        = capturing_q | ~empty | cyc_q;

endmodule

// File: doc/video_capture.md
# video_capture

Video-to-SDRAM frame writer: samples an incoming video stream (HS/VS/BLANK/RGB, same conventions as the VGA output path) and writes each active pixel into the SDRAM framebuffer through a Wishbone classic-cycle master. It is the write-side counterpart of the framebuffer-reading VGA controller, producing the same layout: one 32-bit word per pixel, raster order, byte address +4 per pixel. A small FIFO absorbs Wishbone stalls.

## Interface

- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥2)
- BASE_ADR, 32'h0, byte address of pixel 0

- pixel_clk  in  1  single clock for video inputs and Wishbone
- pixel_rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  capture request, sampled at frame start
- vid_hs, vid_vs  in  1  sync, active-low (idle 1)
- vid_blank  in  1  1 = active pixel
- vid_rgb  in  24  pixel data
- wshb_cyc, wshb_stb, wshb_we  out  1  Wishbone cycle/strobe/write
- wshb_adr  out  32  byte address
- wshb_dat_ms  out  32  {8'h00, rgb}
- wshb_sel  out  4  constant 4'hF
- wshb_cti  out  3  constant 0
- wshb_bte  out  2  constant 0
- wshb_ack  in  1  slave acknowledge
- frame_done  out  1  one-cycle pulse, last pixel of frame acked
- overflow  out  1  sticky, pixel dropped on FIFO full
- busy  out  1  capturing, FIFO non-empty, or cyc high

## Operation

- Reset values: cyc=stb=we=0, adr=BASE_ADR, dat_ms=0, frame_done=0, overflow=0, busy=0; FIFO empty; vs_prev=1; capturing=0.
- Frame start = registered falling edge of vid_vs (vs_prev=1, vid_vs=0). VS held low through reset release is not a frame start.
- At frame start: capturing <= enable; pixel counter <= 0; pending_sof <= 1. Deasserting enable mid-frame has no effect until the next frame start.
- Accept: capturing=1, vid_blank=1, counter < HDISP*VDISP. Each accept increments counter (also when dropped). Non-accepted active pixels ignored.
- FIFO entry = {sof, eof, rgb} (26 bits). sof = pending_sof (cleared when an entry is actually pushed); eof = (counter == HDISP*VDISP-1).
- FIFO full on accept: pixel dropped, overflow <= 1 (cleared only by reset), pending_sof retained.
- Writer states IDLE / WRITE. IDLE, FIFO non-empty: pop, load adr (BASE_ADR if sof, else previous adr+4), dat_ms={8'h00,rgb}, cyc=stb=we=1 -> WRITE. WRITE: hold all outputs until ack. On ack: frame_done pulses if entry eof; FIFO non-empty -> pop and load next entry same edge, stay WRITE (back-to-back); else cyc=stb=we=0 -> IDLE.
- Address arithmetic 32-bit, no wrap other than sof reload; dropped pixels shift later addresses in that frame.
- counter width $clog2(HDISP*VDISP+1).
- Simultaneous push and pop on a full FIFO: allowed, no drop.

## Timing

- Pixel at vid_* sampled on edge N, in FIFO after N; cyc/stb/adr/dat valid after edge N+1 (2-cycle input-to-strobe latency when idle).
- Back-to-back: slave acking every cycle sustains 1 write/cycle, no idle cycles.
- frame_done high the cycle after the eof-entry ack edge, exactly one cycle.
- Asynchronous reset mid-cycle: cyc/stb drop immediately, FIFO and overflow cleared, capture waits for next VS falling edge.

## Test plan

- Reset: assert pixel_rst_n=0 with random inputs -> all outputs at reset values, sel=4'hF, cti=0, bte=0.
- HDISP=4, VDISP=2, ack every cycle, enable=1, 8 active pixels rgb=0..7 after VS fall -> 8 writes adr 0,4..28, dat 0x00000000..0x00000007, single frame_done after 8th ack, overflow=0.
- FIFO_DEPTH=4, ack held low 20 cycles during an 8-pixel line -> first pixels written in order, later ones dropped, overflow=1; next frame first write at adr BASE_ADR.
- enable=0 at VS fall, raised mid-frame -> no Wishbone activity that frame; capture begins at the following VS fall.
- 12 active pixels in an 8-pixel frame -> exactly 8 writes; VS low at reset release -> no capture until a VS 1->0 edge.
- Reset asserted while stb=1 awaiting ack -> cyc/stb 0 without clock edge, busy=0, no frame_done.
